// File: rtl/card_board_if.sv
// Verdict handshake between the card board and the path-algorithm module.
// The board raises chk_req with the two candidate indices and waits for a one-cycle chk_ack.
interface card_board_if #(
    parameter int IDX_W = 4
);
    logic             chk_req;
    logic [IDX_W-1:0] chk_a;
    logic [IDX_W-1:0] chk_b;
    logic             chk_ack;
    logic             chk_ok;

    modport master (
        output chk_req,
        output chk_a,
        output chk_b,
        input  chk_ack,
        input  chk_ok
    );

    modport slave (
        input  chk_req,
        input  chk_a,
        input  chk_b,
        output chk_ack,
        output chk_ok
    );
endinterface

// File: rtl/card_board.sv
// ROWS x COLS memory-card board: cursor, blink phase, two-card selection FSM,
// verdict request to the path-algorithm module and masks for the display.
module card_board #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int IDX_W    = 4,
    parameter int BLINK_W  = 24,
    parameter int SHOW_CYC = 50000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up,
    input  logic                 down,
    input  logic                 left,
    input  logic                 right,
    input  logic                 s,
    card_board_if.master         chk,
    output logic [IDX_W-1:0]     cursor,
    output logic [ROWS*COLS-1:0] sel_mask,
    output logic [ROWS*COLS-1:0] hidden_mask,
    output logic                 blink,
    output logic [IDX_W-1:0]     pairs_left,
    output logic                 done
);
    localparam int N      = ROWS * COLS;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int HOLD_W = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;
    localparam logic [N-1:0] BIT0 = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ONE, CHECK, SHOW} state_t;

    state_t             state_reg, state_next;
    logic [ROW_W-1:0]   row_reg, row_next;
    logic [COL_W-1:0]   col_reg, col_next;
    logic [IDX_W-1:0]   cursor_reg, cursor_next;
    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               blink_reg;
    logic [N-1:0]       sel_reg, sel_next;
    logic [N-1:0]       hidden_reg, hidden_next;
    logic [IDX_W-1:0]   chk_a_reg, chk_a_next;
    logic [IDX_W-1:0]   chk_b_reg, chk_b_next;
    logic               chk_req_reg, chk_req_next;
    logic [IDX_W-1:0]   pairs_reg, pairs_next;
    logic               done_reg, done_next;
    logic [HOLD_W-1:0]  hold_reg, hold_next;

    logic [N-1:0] cur_bit, a_bit, b_bit;
    logic         cur_hidden;

    // Cursor kept as row/col so wrap-around never crosses rows.
    always_comb begin
        row_next = row_reg;
        col_next = col_reg;
        if (up) begin
            row_next = (row_reg == '0) ? ROW_W'(ROWS - 1) : row_reg - ROW_W'(1);
        end else if (down) begin
            row_next = (row_reg == ROW_W'(ROWS - 1)) ? '0 : row_reg + ROW_W'(1);
        end else if (left) begin
            col_next = (col_reg == '0) ? COL_W'(COLS - 1) : col_reg - COL_W'(1);
        end else if (right) begin
            col_next = (col_reg == COL_W'(COLS - 1)) ? '0 : col_reg + COL_W'(1);
        end
        cursor_next = IDX_W'(row_next) * IDX_W'(COLS) + IDX_W'(col_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_reg    <= '0;
            col_reg    <= '0;
            cursor_reg <= '0;
        end else begin
            row_reg    <= row_next;
            col_reg    <= col_next;
            cursor_reg <= cursor_next;
        end
    end

    // Free-running divider; the phase flips each time it wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_reg <= '0;
            blink_reg     <= 1'b0;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
            if (&blink_cnt_reg) begin
                blink_reg <= ~blink_reg;
            end
        end
    end

    // Selection acts on the registered (pre-move) cursor.
    assign cur_bit    = BIT0 << cursor_reg;
    assign a_bit      = BIT0 << chk_a_reg;
    assign b_bit      = BIT0 << chk_b_reg;
    assign cur_hidden = (hidden_reg & cur_bit) != '0;

    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        hidden_next  = hidden_reg;
        chk_a_next   = chk_a_reg;
        chk_b_next   = chk_b_reg;
        chk_req_next = chk_req_reg;
        pairs_next   = pairs_reg;
        done_next    = done_reg;
        hold_next    = hold_reg;
        case (state_reg)
            IDLE: begin
                if (s && !done_reg && !cur_hidden) begin
                    sel_next   = sel_reg | cur_bit;
                    chk_a_next = cursor_reg;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (s) begin
                    if (cursor_reg == chk_a_reg) begin
                        sel_next   = sel_reg & ~cur_bit;
                        state_next = IDLE;
                    end else if (!cur_hidden) begin
                        sel_next     = sel_reg | cur_bit;
                        chk_b_next   = cursor_reg;
                        chk_req_next = 1'b1;
                        state_next   = CHECK;
                    end
                end
            end
            CHECK: begin
                if (chk.chk_ack) begin
                    chk_req_next = 1'b0;
                    if (chk.chk_ok) begin
                        sel_next    = sel_reg & ~(a_bit | b_bit);
                        hidden_next = hidden_reg | a_bit | b_bit;
                        pairs_next  = pairs_reg - IDX_W'(1);
                        if (pairs_reg == IDX_W'(1)) begin
                            done_next = 1'b1;
                        end
                        state_next  = IDLE;
                    end else begin
                        hold_next  = HOLD_W'(SHOW_CYC - 1);
                        state_next = SHOW;
                    end
                end
            end
            SHOW: begin
                // Counts SHOW_CYC-1 down to zero, so the pair stays up SHOW_CYC cycles after the verdict.
                if (hold_reg == '0) begin
                    sel_next   = sel_reg & ~(a_bit | b_bit);
                    state_next = IDLE;
                end else begin
                    hold_next = hold_reg - HOLD_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            sel_reg     <= '0;
            hidden_reg  <= '0;
            chk_a_reg   <= '0;
            chk_b_reg   <= '0;
            chk_req_reg <= 1'b0;
            pairs_reg   <= IDX_W'(N / 2);
            done_reg    <= 1'b0;
            hold_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            hidden_reg  <= hidden_next;
            chk_a_reg   <= chk_a_next;
            chk_b_reg   <= chk_b_next;
            chk_req_reg <= chk_req_next;
            pairs_reg   <= pairs_next;
            done_reg    <= done_next;
            hold_reg    <= hold_next;
        end
    end

    assign cursor      = cursor_reg;
    assign sel_mask    = sel_reg;
    assign hidden_mask = hidden_reg;
    assign blink       = blink_reg;
    assign pairs_left  = pairs_reg;
    assign done        = done_reg;
    assign chk.chk_req = chk_req_reg;
    assign chk.chk_a   = chk_a_reg;
    assign chk.chk_b   = chk_b_reg;
endmodule

// File: tb/tb_card_board.sv
// Self-checking bench for card_board on a 4x4 board with a short blink divider and show time.
module tb_card_board;
    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int N        = ROWS * COLS;
    localparam int IDX_W    = 4;
    localparam int BLINK_W  = 3;
    localparam int SHOW_CYC = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, s = 1'b0;
    logic [IDX_W-1:0] cursor, pairs_left;
    logic [N-1:0]     sel_mask, hidden_mask;
    logic             blink, done;

    card_board_if #(.IDX_W(IDX_W)) chk_if ();

    card_board #(
        .ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W), .BLINK_W(BLINK_W), .SHOW_CYC(SHOW_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .up(up), .down(down), .left(left), .right(right), .s(s),
        .chk(chk_if.master),
        .cursor(cursor), .sel_mask(sel_mask), .hidden_mask(hidden_mask),
        .blink(blink), .pairs_left(pairs_left), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0] a;
        logic [IDX_W-1:0] b;
    } req_t;

    req_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    int           exp_cur = 0;
    logic [N-1:0] exp_hidden = '0;
    int           exp_pairs = N / 2;

    // Structural invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if ($countones(sel_mask) > 2 || (sel_mask & hidden_mask) != '0) begin
                errors++;
                $display("FAIL invariant: sel_mask=%h hidden_mask=%h", sel_mask, hidden_mask);
            end
        end
    end

    task automatic step(input logic u, input logic d, input logic l, input logic r, input logic sv);
        up = u; down = d; left = l; right = r; s = sv;
        @(posedge clk); #1;
        up = 0; down = 0; left = 0; right = 0; s = 0;
    endtask

    task automatic ack(input logic ok);
        chk_if.chk_ack = 1'b1;
        chk_if.chk_ok  = ok;
        @(posedge clk); #1;
        chk_if.chk_ack = 1'b0;
        chk_if.chk_ok  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cur    = 0;
        exp_hidden = '0;
        exp_pairs  = N / 2;
        sb_q.delete();
    endtask

    task automatic goto(input int t);
        while (exp_cur % COLS != t % COLS) begin
            step(0, 0, 0, 1, 0);
            exp_cur = (exp_cur / COLS) * COLS + (exp_cur % COLS + 1) % COLS;
        end
        while (exp_cur / COLS != t / COLS) begin
            step(0, 1, 0, 0, 0);
            exp_cur = ((exp_cur / COLS + 1) % ROWS) * COLS + exp_cur % COLS;
        end
        checks++;
        if (cursor !== IDX_W'(t)) begin
            errors++;
            $display("FAIL goto: cursor=%0d expected %0d", cursor, t);
        end
    endtask

    // Selects a then b; the expected request goes to the scoreboard and is popped when chk_req shows up.
    task automatic pick_pair(input int a, input int b);
        req_t exp;
        int   n;
        goto(a);
        step(0, 0, 0, 0, 1);
        goto(b);
        exp.a = IDX_W'(a);
        exp.b = IDX_W'(b);
        sb_q.push_back(exp);
        step(0, 0, 0, 0, 1);
        n = 0;
        while (chk_if.chk_req !== 1'b1 && n < 8) begin
            step(0, 0, 0, 0, 0);
            n++;
        end
        exp = sb_q.pop_front();
        checks++;
        if (chk_if.chk_req !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout: chk_req=%b expected 1 for pair %0d,%0d", chk_if.chk_req, a, b);
        end else if (chk_if.chk_a !== exp.a || chk_if.chk_b !== exp.b) begin
            errors++;
            $display("FAIL req_indices: chk_a=%0d chk_b=%0d expected %0d,%0d",
                     chk_if.chk_a, chk_if.chk_b, exp.a, exp.b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cursor !== '0 || sel_mask !== '0 || hidden_mask !== '0 || chk_if.chk_req !== 1'b0 ||
            chk_if.chk_a !== '0 || chk_if.chk_b !== '0 || blink !== 1'b0 ||
            pairs_left !== IDX_W'(N / 2) || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: cur=%0d sel=%h hid=%h req=%b a=%0d b=%0d blink=%b pairs=%0d done=%b expected 0,0,0,0,0,0,0,%0d,0",
                     cursor, sel_mask, hidden_mask, chk_if.chk_req, chk_if.chk_a, chk_if.chk_b,
                     blink, pairs_left, done, N / 2);
        end
        rst = 1'b0;
    endtask

    task automatic test_blink();
        logic b0;
        int   n;
        b0 = blink;
        n  = 0;
        while (blink === b0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        b0 = blink;
        n  = 0;
        while (blink === b0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != (1 << BLINK_W)) begin
            errors++;
            $display("FAIL blink_period: %0d cycles expected %0d", n, 1 << BLINK_W);
        end
    endtask

    task automatic test_cursor();
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        checks++;
        if (cursor !== 4'd1) begin errors++; $display("FAIL right_wrap: cursor=%0d expected 1", cursor); end
        step(1, 0, 0, 0, 0);
        checks++;
        if (cursor !== 4'd13) begin errors++; $display("FAIL up_wrap: cursor=%0d expected 13", cursor); end
        step(1, 0, 1, 0, 0);
        checks++;
        if (cursor !== 4'd9) begin errors++; $display("FAIL up_priority: cursor=%0d expected 9", cursor); end
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        checks++;
        if (cursor !== 4'd11) begin errors++; $display("FAIL left_wrap: cursor=%0d expected 11", cursor); end
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        checks++;
        if (cursor !== 4'd3) begin errors++; $display("FAIL down_wrap: cursor=%0d expected 3", cursor); end
        exp_cur = 3;
    endtask

    task automatic test_match();
        pick_pair(0, 5);
        checks++;
        if (sel_mask !== 16'h0021) begin errors++; $display("FAIL match_sel: sel_mask=%h expected 0021", sel_mask); end
        ack(1'b1);
        exp_hidden = 16'h0021;
        exp_pairs  = 7;
        checks++;
        if (hidden_mask !== exp_hidden || sel_mask !== '0 || pairs_left !== 4'd7 || chk_if.chk_req !== 1'b0) begin
            errors++;
            $display("FAIL match_result: hid=%h sel=%h pairs=%0d req=%b expected 0021,0000,7,0",
                     hidden_mask, sel_mask, pairs_left, chk_if.chk_req);
        end
    endtask

    task automatic test_mismatch();
        pick_pair(2, 3);
        step(0, 0, 0, 0, 1);
        checks++;
        if (chk_if.chk_req !== 1'b1 || sel_mask !== 16'h000C || chk_if.chk_a !== 4'd2 || chk_if.chk_b !== 4'd3) begin
            errors++;
            $display("FAIL check_hold: req=%b sel=%h a=%0d b=%0d expected 1,000c,2,3",
                     chk_if.chk_req, sel_mask, chk_if.chk_a, chk_if.chk_b);
        end
        ack(1'b0);
        for (int i = 0; i < SHOW_CYC; i++) begin
            checks++;
            if (sel_mask !== 16'h000C || chk_if.chk_req !== 1'b0) begin
                errors++;
                $display("FAIL show_hold: cycle %0d sel=%h req=%b expected 000c,0", i, sel_mask, chk_if.chk_req);
            end
            step(0, 0, 0, 0, i[0]);
        end
        checks++;
        if (sel_mask !== '0 || hidden_mask !== exp_hidden || pairs_left !== 4'd7) begin
            errors++;
            $display("FAIL show_clear: sel=%h hid=%h pairs=%0d expected 0000,%h,7", sel_mask, hidden_mask, exp_hidden, pairs_left);
        end
    endtask

    task automatic test_deselect();
        goto(4);
        step(0, 0, 0, 0, 1);
        checks++;
        if (sel_mask !== 16'h0010) begin errors++; $display("FAIL desel_first: sel=%h expected 0010", sel_mask); end
        step(0, 0, 0, 0, 1);
        checks++;
        if (sel_mask !== '0 || chk_if.chk_req !== 1'b0) begin
            errors++;
            $display("FAIL desel_second: sel=%h req=%b expected 0000,0", sel_mask, chk_if.chk_req);
        end
        ack(1'b1);
        checks++;
        if (hidden_mask !== exp_hidden || pairs_left !== 4'd7) begin
            errors++;
            $display("FAIL stray_ack: hid=%h pairs=%0d expected %h,7", hidden_mask, pairs_left, exp_hidden);
        end
        goto(0);
        step(0, 0, 0, 0, 1);
        checks++;
        if (sel_mask !== '0) begin errors++; $display("FAIL hidden_select: sel=%h expected 0000", sel_mask); end
    endtask

    task automatic test_simultaneous();
        goto(6);
        step(0, 0, 0, 1, 1);
        exp_cur = 7;
        checks++;
        if (sel_mask !== 16'h0040 || cursor !== 4'd7) begin
            errors++;
            $display("FAIL sel_and_move: sel=%h cur=%0d expected 0040,7", sel_mask, cursor);
        end
        step(0, 0, 1, 0, 0);
        exp_cur = 6;
        step(0, 0, 0, 0, 1);
        checks++;
        if (sel_mask !== '0) begin errors++; $display("FAIL sim_deselect: sel=%h expected 0000", sel_mask); end
    endtask

    task automatic test_all_pairs();
        int pa[7] = '{1, 3, 6, 8, 10, 12, 14};
        for (int i = 0; i < 7; i++) begin
            pick_pair(pa[i], pa[i] + 1);
            ack(1'b1);
            exp_hidden = exp_hidden | (N'(1) << pa[i]) | (N'(1) << (pa[i] + 1));
            exp_pairs--;
            checks++;
            if (hidden_mask !== exp_hidden || pairs_left !== IDX_W'(exp_pairs) || done !== (exp_pairs == 0)) begin
                errors++;
                $display("FAIL pair_%0d: hid=%h pairs=%0d done=%b expected %h,%0d,%b",
                         pa[i], hidden_mask, pairs_left, done, exp_hidden, exp_pairs, exp_pairs == 0);
            end
        end
        checks++;
        if (done !== 1'b1 || pairs_left !== '0 || hidden_mask !== 16'hFFFF) begin
            errors++;
            $display("FAIL game_done: done=%b pairs=%0d hid=%h expected 1,0,ffff", done, pairs_left, hidden_mask);
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        checks++;
        if (sel_mask !== '0 || chk_if.chk_req !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL after_done: sel=%h req=%b done=%b expected 0000,0,1", sel_mask, chk_if.chk_req, done);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(0, 0, 0, 0, 1);
        goto(1);
        step(0, 0, 0, 0, 1);
        checks++;
        if (chk_if.chk_req !== 1'b1) begin errors++; $display("FAIL mid_req: req=%b expected 1", chk_if.chk_req); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (chk_if.chk_req !== 1'b0 || sel_mask !== '0 || cursor !== '0 || pairs_left !== IDX_W'(N / 2)) begin
            errors++;
            $display("FAIL async_reset: req=%b sel=%h cur=%0d pairs=%0d expected 0,0000,0,%0d",
                     chk_if.chk_req, sel_mask, cursor, pairs_left, N / 2);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cur = 0;
        ack(1'b1);
        checks++;
        if (hidden_mask !== '0 || pairs_left !== IDX_W'(N / 2) || chk_if.chk_req !== 1'b0 || sel_mask !== '0) begin
            errors++;
            $display("FAIL late_ack: hid=%h pairs=%0d req=%b sel=%h expected 0000,%0d,0,0000",
                     hidden_mask, pairs_left, chk_if.chk_req, sel_mask, N / 2);
        end
    endtask

    initial begin
        chk_if.chk_ack = 1'b0;
        chk_if.chk_ok  = 1'b0;
        test_reset();
        test_blink();
        test_cursor();
        test_match();
        test_mismatch();
        test_deselect();
        test_simultaneous();
        test_all_pairs();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
